mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, giving the maximum cycles in ACCESS without mem_ready.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port req, input, 1: access request, sampled only in IDLE.
REQ-005 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have port req_size, input, 1: 1 = byte, 0 = word.
REQ-007 SHALL have port req_addr, input, 16: byte address.
REQ-008 SHALL have port req_wdata, input, 16: write data.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1: valid with done; 1 = misaligned or timed-out access.
REQ-012 SHALL have port rdata, output, 16: read result, held until next completed read.
REQ-013 SHALL have port mem_en, output, 1: bus cycle active.
REQ-014 SHALL have port mem_r_w, output, 1: 1 = write.
REQ-015 SHALL have port mem_size, output, 1: 1 = byte.
REQ-016 SHALL have ports mem_addr and mem_wdata, output, 16 each: registered address and write data.
REQ-017 SHALL have port mem_rdata, input, 16: memory read data.
REQ-018 SHALL have port mem_ready, input, 1: memory completes the access this cycle.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-020 IDLE with req=1 SHALL capture req_we, req_size, req_addr and req_wdata into registers on that edge.
REQ-021 IDLE with req=1 SHALL go to ACCESS if the access is aligned, or to DONE with err=1 otherwise.
REQ-022 Misaligned SHALL mean req_size=0 and req_addr[0]=1; a misaligned request SHALL never assert mem_en.
REQ-023 In ACCESS, mem_en SHALL be 1 and mem_r_w, mem_size, mem_addr and mem_wdata SHALL hold their captured values stable.
REQ-024 ACCESS with mem_ready=1 SHALL go to DONE with err=0, and a read SHALL load rdata on that same edge.
REQ-025 A word read SHALL load rdata = mem_rdata; a byte read SHALL load rdata = {8'h00, mem_rdata[7:0]}.
REQ-026 A byte write SHALL drive mem_wdata = {8'h00, req_wdata[7:0]}; a word write SHALL drive req_wdata unchanged.
REQ-027 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-028 Minimum latency SHALL be: req high at edge N, mem_en high in cycle N+1, mem_ready high in N+1, done high in N+2.
REQ-029 req SHALL be ignored while busy=1, with no queuing; a req held high through DONE SHALL start a new access from IDLE.
REQ-030 Back-to-back throughput SHALL be one access per 3 cycles minimum.
REQ-031 mem_en, done and err SHALL be 0 in IDLE; err SHALL be meaningful only while done=1 and 0 otherwise.
REQ-032 rdata SHALL be unchanged by writes, misaligned accesses and timeouts.

Reset
REQ-033 When reset=0 at posedge clk, the FSM SHALL go to IDLE and busy, done, err and mem_en SHALL be 0.
REQ-034 When reset=0 at posedge clk, rdata, mem_addr and mem_wdata SHALL be 16'h0000, and mem_r_w and mem_size SHALL be 0.
REQ-035 Reset asserted mid-ACCESS SHALL abort the access: mem_en low after that edge, and no done pulse.
REQ-036 Reset SHALL take priority over req and mem_ready on the same edge.

Configuration
REQ-037 Macro MEM_ACCESS_TIMEOUT_EN defined SHALL add a cycle counter cleared on entry to ACCESS and incremented each ACCESS cycle without mem_ready.
REQ-038 With MEM_ACCESS_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without mem_ready SHALL drop mem_en and go to DONE with err=1.
REQ-039 With MEM_ACCESS_TIMEOUT_EN defined, mem_ready on the same cycle the limit is reached SHALL win, giving err=0.
REQ-040 With MEM_ACCESS_TIMEOUT_EN undefined, there SHALL be no counter, ACCESS SHALL wait indefinitely for mem_ready, and err SHALL be raised only for misalignment.

Verification
REQ-041 Word write: req_addr=16'h3000, req_wdata=16'hBEEF, mem_ready high in first ACCESS cycle -> mem_en, mem_r_w=1, mem_addr=16'h3000, mem_wdata=16'hBEEF for 1 cycle; done 2 cycles after req; err=0.
REQ-042 Byte read: req_addr=16'h3001, mem_rdata=16'h12A5, mem_ready delayed 3 cycles -> mem_en high for 4 cycles; rdata=16'h00A5; done on the following cycle.
REQ-043 Misaligned: word read at 16'h3001 -> mem_en never high; done and err high 1 cycle after req; rdata unchanged.
REQ-044 Reset mid-access: reset=0 during the second ACCESS cycle -> mem_en=0, busy=0 and rdata=16'h0000 next cycle; no done.
REQ-045 Timeout (macro defined, TIMEOUT_CYCLES=4): mem_ready held 0 -> mem_en high exactly 4 cycles; then done=1 with err=1. With the macro undefined -> mem_en stays high until mem_ready.
REQ-046 Busy ignore: req pulsed during ACCESS -> no second bus cycle; req held continuously -> new access captured on the edge after DONE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller: IDLE -> ACCESS -> DONE handshake to a simple bus.
// Optional ACCESS timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for req; captures request fields on req
//   ACCESS | bus cycle in progress, waiting for mem_ready
//   DONE   | one-cycle completion pulse, err qualifies it
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_size,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_r_w,
    output logic        mem_size,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic        size_q, size_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (req) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    // byte writes present only the low lane on the bus
                    wdata_d = req_size ? {8'h00, req_wdata[7:0]} : req_wdata;
                    if (!req_size && req_addr[0]) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = size_q ? {8'h00, mem_rdata[7:0]} : mem_rdata;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_en    = (state_q == ACCESS);
    assign mem_r_w   = we_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected completions queued at request time,
// checked by a monitor when done pulses.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, req_we, req_size;
    logic [15:0] req_addr, req_wdata;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic        mem_en, mem_r_w, mem_size;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_en(mem_en), .mem_r_w(mem_r_w), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    logic [15:0] model_rdata = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_en) en_cnt++;
        if (!done && err) chk("err_without_done", err, 0);
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_err", err, e.err);
                chk("done_rdata", rdata, e.rdata);
                chk("done_latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic we, input logic sz, input logic [15:0] addr,
                             input logic [15:0] wd, input logic [15:0] mrd,
                             input int delay, input logic poke);
        logic        mis;
        logic [15:0] exp_wd;
        exp_t        e;
        mis    = !sz && addr[0];
        exp_wd = sz ? {8'h00, wd[7:0]} : wd;
        e.err   = mis;
        e.rdata = (mis || we) ? model_rdata : (sz ? {8'h00, mrd[7:0]} : mrd);
        e.t0    = cyc;
        e.lat   = mis ? 1 : delay + 2;
        model_rdata = e.rdata;
        exp_q.push_back(e);
        req = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
        en_cnt = 0;
        tick();
        req = 1'b0;
        if (!mis) begin
            for (int i = 0; i <= delay; i++) begin
                chk("mem_en", mem_en, 1);
                chk("mem_addr", mem_addr, addr);
                chk("mem_r_w", mem_r_w, we);
                chk("mem_size", mem_size, sz);
                if (we) chk("mem_wdata", mem_wdata, exp_wd);
                mem_ready = (i == delay);
                mem_rdata = mrd;
                req = poke && (i == 0);
                tick();
            end
        end else begin
            chk("mis_mem_en", mem_en, 0);
        end
        mem_ready = 1'b0;
        req = 1'b0;
        tick();
        chk("busy_after", busy, 0);
        chk("en_cycles", en_cnt, mis ? 0 : delay + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b0; req = 1'b0; req_we = 1'b0; req_size = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; mem_rdata = 16'h0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_rw_size", {mem_r_w, mem_size}, 2'b00);
        reset = 1'b1;
        tick();

        do_access(1'b1, 1'b0, 16'h3000, 16'hBEEF, 16'h0000, 0, 1'b0);
        do_access(1'b0, 1'b1, 16'h3001, 16'h0000, 16'h12A5, 3, 1'b0);
        do_access(1'b0, 1'b0, 16'h3001, 16'h0000, 16'hFFFF, 0, 1'b0);
        do_access(1'b1, 1'b1, 16'h3001, 16'h55AA, 16'h0000, 0, 1'b0);
        do_access(1'b0, 1'b0, 16'h1234, 16'h0000, 16'hCAFE, 1, 1'b0);
        do_access(1'b1, 1'b0, 16'h2002, 16'h7E57, 16'h0000, 2, 1'b1);

        // req held high: second access starts from IDLE, three cycles after the first
        e.err = 1'b0; e.rdata = model_rdata; e.lat = 2;
        e.t0 = cyc;     exp_q.push_back(e);
        e.t0 = cyc + 3; exp_q.push_back(e);
        req = 1'b1; req_we = 1'b1; req_size = 1'b0; req_addr = 16'h0100; req_wdata = 16'h1111;
        mem_ready = 1'b1; en_cnt = 0;
        repeat (4) tick();
        req = 1'b0;
        repeat (2) tick();
        mem_ready = 1'b0;
        chk("held_en_cycles", en_cnt, 2);
        chk("held_busy", busy, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        e.err = 1'b1; e.rdata = model_rdata; e.t0 = cyc; e.lat = 5;
        exp_q.push_back(e);
        req = 1'b1; req_we = 1'b0; req_size = 1'b0; req_addr = 16'h4000;
        mem_rdata = 16'h9999; en_cnt = 0;
        tick();
        req = 1'b0;
        repeat (5) tick();
        chk("tmo_en_cycles", en_cnt, 4);
        chk("tmo_busy", busy, 0);
`else
        do_access(1'b0, 1'b0, 16'h4000, 16'h0000, 16'h9999, 10, 1'b0);
`endif

        // reset during the second ACCESS cycle, colliding with req and mem_ready
        req = 1'b1; req_we = 1'b0; req_size = 1'b1; req_addr = 16'h2000;
        tick();
        req = 1'b0;
        tick();
        chk("abort_in_access", mem_en, 1);
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h4321; req = 1'b1;
        tick();
        chk("abort_mem_en", mem_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rdata", rdata, 16'h0000);
        chk("abort_mem_addr", mem_addr, 16'h0000);
        reset = 1'b1; mem_ready = 1'b0; req = 1'b0;
        model_rdata = 16'h0000;
        tick();
        chk("abort_idle_done", done, 0);

        do_access(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h7781, 0, 1'b0);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
